// File: rtl/noc_pkg.sv
// Shared definitions for the mesh-router input-port blocks.
//   FLIT_W_DEFAULT : default flit width in bits
//   vc_idx_w()     : width of a VC index (clog2 with a minimum of 1)
//   cnt_w()        : width of an occupancy count able to hold 0..DEPTH
package noc_pkg;

    localparam int FLIT_W_DEFAULT = 8;

    function automatic int vc_idx_w(input int num_vc);
        return (num_vc <= 1) ? 1 : $clog2(num_vc);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vc_fifo_bank.sv
// One virtual channel's circular buffer.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push     : store din at the write pointer (caller guarantees room)
//   pop      : advance the read pointer (caller guarantees data)
//   din      : flit to store
//   dout     : flit at the read pointer, combinational
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupancy 0..DEPTH
module vc_fifo_bank
    import noc_pkg::*;
#(
    parameter int DATA_W = FLIT_W_DEFAULT,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally at AW bits because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/router_vc_fifo.sv
// Router input-port buffer: NUM_VC independent DEPTH-entry FIFOs with a
// registered read port and one credit returned per accepted read.
//   clk, rst       : clock, asynchronous active-high reset
//   wr_en/wr_vc/wr_data : write request, target VC, flit
//   rd_en/rd_vc    : read request, source VC
//   rd_data        : registered read flit (holds when no read accepted)
//   rd_valid       : rd_data was updated by the last edge
//   credit_valid/credit_vc : one credit returned upstream for that VC
//   full, empty    : per-VC status flags
//   count          : per-VC occupancy, VC0 in the LSBs
//   err_overflow   : sticky, a write was dropped
//   err_underflow  : sticky, a read was rejected
module router_vc_fifo
    import noc_pkg::*;
#(
    parameter int DATA_W = FLIT_W_DEFAULT,
    parameter int DEPTH  = 8,
    parameter int NUM_VC = 2,
    localparam int VW    = vc_idx_w(NUM_VC),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [VW-1:0]        wr_vc,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [VW-1:0]        rd_vc,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 credit_valid,
    output logic [VW-1:0]        credit_vc,
    output logic [NUM_VC-1:0]    full,
    output logic [NUM_VC-1:0]    empty,
    output logic [NUM_VC*CW-1:0] count,
    output logic                 err_overflow,
    output logic                 err_underflow
);

    logic [DATA_W-1:0] dout_v [NUM_VC];
    logic [NUM_VC-1:0] push_v;
    logic [NUM_VC-1:0] pop_v;

    logic              wr_vc_ok_p0;
    logic              rd_vc_ok_p0;
    logic              rd_empty_sel_p0;
    logic              wr_full_sel_p0;
    logic [DATA_W-1:0] rd_dout_sel_p0;
    logic              rd_acc_p0;
    logic              wr_acc_p0;

    // Stage p0: request decode and acceptance
    assign wr_vc_ok_p0 = ({1'b0, wr_vc} < (VW+1)'(NUM_VC));
    assign rd_vc_ok_p0 = ({1'b0, rd_vc} < (VW+1)'(NUM_VC));

    // Out-of-range VCs select nothing and look empty/full, which rejects them.
    always_comb begin
        rd_empty_sel_p0 = 1'b1;
        wr_full_sel_p0  = 1'b1;
        rd_dout_sel_p0  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_vc == VW'(v)) begin
                rd_empty_sel_p0 = empty[v];
                rd_dout_sel_p0  = dout_v[v];
            end
            if (wr_vc == VW'(v)) begin
                wr_full_sel_p0 = full[v];
            end
        end
    end

    assign rd_acc_p0 = rd_en && rd_vc_ok_p0 && !rd_empty_sel_p0;

    // A full VC still takes a write when the same edge frees a slot in it.
    assign wr_acc_p0 = wr_en && wr_vc_ok_p0 &&
                       (!wr_full_sel_p0 || (rd_acc_p0 && (rd_vc == wr_vc)));

    always_comb begin
        push_v = '0;
        pop_v  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push_v[v] = wr_acc_p0 && (wr_vc == VW'(v));
            pop_v[v]  = rd_acc_p0 && (rd_vc == VW'(v));
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        logic [CW-1:0] cnt;

        vc_fifo_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .push  (push_v[g]),
            .pop   (pop_v[g]),
            .din   (wr_data),
            .dout  (dout_v[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (cnt)
        );

        assign count[g*CW +: CW] = cnt;
    end

    // Stage p1: registered read port, credit return and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            credit_valid  <= 1'b0;
            credit_vc     <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            rd_valid     <= rd_acc_p0;
            credit_valid <= rd_acc_p0;
            if (rd_acc_p0) begin
                rd_data   <= rd_dout_sel_p0;
                credit_vc <= rd_vc;
            end
            if (wr_en && !wr_acc_p0) err_overflow  <= 1'b1;
            if (rd_en && !rd_acc_p0) err_underflow <= 1'b1;
        end
    end

endmodule
